axi_default_slave: RTL and testbench



---
 rtl/axi_default_slave.sv | 169 ++++++++++++++++
 tb/tb_axi_default_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_default_slave.sv
// rtl/axi_default_slave.sv - AXI terminating slave; answers every access with DECERR.
// Reads return LEN+1 zero beats; writes drain W up to WLAST, then issue one B response.
module axi_default_slave #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDS_W-1:0]    ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [IDS_W-1:0]    RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [IDS_W-1:0]    AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [IDS_W-1:0]    BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY
);

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  r_state_e         r_state_q, r_state_d;
  w_state_e         w_state_q, w_state_d;
  logic [IDS_W-1:0] rid_q, rid_d, bid_q, bid_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

  // Address, size, burst and write payload are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{ARADDR, ARSIZE, ARBURST, AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB};

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          rid_d     = ARID;
          len_d     = ARLEN;
          cnt_d     = '0;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (ARLEN == '0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            rlast_d = ((cnt_q + LEN_W'(1)) == len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID && awready_q) begin
          bid_d     = AWID;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // AWLEN is not tracked; the master's WLAST alone closes the burst.
        if (WVALID && WLAST) begin
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      rid_q     <= '0;
      bid_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      rid_q     <= rid_d;
      bid_q     <= bid_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign ARREADY = arready_q;
  assign RID     = rid_q;
  assign RDATA   = '0;
  assign RRESP   = 2'b11;
  assign RLAST   = rlast_q;
  assign RVALID  = rvalid_q;
  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BID     = bid_q;
  assign BRESP   = 2'b11;
  assign BVALID  = bvalid_q;

endmodule

// File: tb/tb_axi_default_slave.sv
// tb/tb_axi_default_slave.sv - Bench for axi_default_slave.
// Vector tables drive reads/writes; R and B responses are checked against scoreboard queues.
module tb_axi_default_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ARID = '0, AWID = '0;
  logic [31:0] ARADDR = '0, AWADDR = '0, WDATA = '0;
  logic [3:0]  ARLEN = '0, AWLEN = '0, WSTRB = '0;
  logic [2:0]  ARSIZE = '0, AWSIZE = '0;
  logic [1:0]  ARBURST = '0, AWBURST = '0;
  logic        ARVALID = 1'b0, RREADY = 1'b0, AWVALID = 1'b0;
  logic        WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
  logic        ARREADY, RLAST, RVALID, AWREADY, WREADY, BVALID;
  logic [7:0]  RID, BID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP, BRESP;

  axi_default_slave dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] id; logic last; } rbeat_t;
  typedef struct { logic [7:0] id; logic [3:0] len; logic [15:0] mask; } rvec_t;
  typedef struct { logic [7:0] id; int nbeats; int bdelay; } wvec_t;

  rbeat_t     r_exp[$];
  logic [7:0] b_exp[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard pop on the negedge before each handshake edge, plus R stall stability.
  logic       prev_rv = 1'b0, prev_rr = 1'b0, prev_rl = 1'b0;
  logic [7:0] prev_rid = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0;
      prev_rr = 1'b0;
    end else begin
      if (prev_rv && !prev_rr) begin
        chk("r_stall_valid", RVALID, 1);
        chk("r_stall_id", RID, prev_rid);
        chk("r_stall_last", RLAST, prev_rl);
      end
      if (RVALID && RREADY) begin
        if (r_exp.size() == 0) chk("r_unexpected_beat", 1, 0);
        else begin
          rbeat_t e;
          e = r_exp.pop_front();
          chk("r_id", RID, e.id);
          chk("r_last", RLAST, e.last);
          chk("r_data", RDATA, 0);
          chk("r_resp", RRESP, 2'b11);
        end
      end
      if (BVALID && BREADY) begin
        if (b_exp.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          chk("b_id", BID, b_exp.pop_front());
          chk("b_resp", BRESP, 2'b11);
        end
      end
      prev_rv = RVALID; prev_rr = RREADY; prev_rl = RLAST; prev_rid = RID;
    end
  end

  task automatic do_read(input logic [7:0] id, input logic [3:0] len, input logic [15:0] mask);
    bit got = 0;
    int beats = 0;
    int cyc = 0;
    ARID = id; ARLEN = len; ARVALID = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      got = ARREADY;
      @(posedge clk); #1;
    end
    ARVALID = 1'b0;
    if (!got) begin chk("ar_timeout", 0, 1); return; end
    for (int k = 0; k <= int'(len); k++) r_exp.push_back('{id, k == int'(len)});
    chk("ar_rvalid_latency", RVALID, 1);
    chk("ar_arready_low", ARREADY, 0);
    chk("ar_rlast_first", RLAST, len == 4'd0);
    while (beats <= int'(len) && cyc < 200) begin
      RREADY = mask[cyc % 16];
      if (RVALID && RREADY) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    RREADY = 1'b0;
    chk("r_beat_count", beats, int'(len) + 1);
    chk("r_done_rvalid", RVALID, 0);
    chk("r_done_arready", ARREADY, 1);
  endtask

  task automatic do_write(input logic [7:0] id, input int nbeats, input int bdelay);
    bit got = 0;
    AWID = id; AWVALID = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      got = AWREADY;
      @(posedge clk); #1;
    end
    AWVALID = 1'b0;
    if (!got) begin chk("aw_timeout", 0, 1); return; end
    b_exp.push_back(id);
    chk("aw_awready_low", AWREADY, 0);
    chk("aw_wready", WREADY, 1);
    for (int b = 0; b < nbeats; b++) begin
      WDATA = $urandom; WSTRB = 4'hf; WVALID = 1'b1; WLAST = (b == nbeats - 1);
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        got = WREADY;
        @(posedge clk); #1;
      end
      if (!got) chk("w_timeout", 0, 1);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("w_end_wready", WREADY, 0);
    chk("w_end_bvalid", BVALID, 1);
    chk("w_end_bid", BID, id);
    for (int d = 0; d < bdelay; d++) begin
      BREADY = 1'b0;
      chk("b_hold", BVALID, 1);
      @(posedge clk); #1;
    end
    BREADY = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      got = BVALID;
      @(posedge clk); #1;
    end
    BREADY = 1'b0;
    if (!got) chk("b_timeout", 0, 1);
    chk("b_done_bvalid", BVALID, 0);
    chk("b_done_awready", AWREADY, 1);
  endtask

  rvec_t rv[4];
  wvec_t wv[3];

  initial begin
    rv[0] = '{8'h12, 4'd0,  16'hffff};
    rv[1] = '{8'ha3, 4'd3,  16'hffed};
    rv[2] = '{8'h5a, 4'd15, 16'haaaa};
    rv[3] = '{8'hc7, 4'd7,  16'h3333};
    wv[0] = '{8'h25, 2, 3};
    wv[1] = '{8'h81, 1, 0};
    wv[2] = '{8'he0, 4, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", ARREADY, 1);
    chk("rst_awready", AWREADY, 1);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rid", RID, 0);
    chk("rst_bid", BID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_rresp", RRESP, 2'b11);
    chk("rst_bresp", BRESP, 2'b11);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) do_read(rv[i].id, rv[i].len, rv[i].mask);
    for (int i = 0; i < 3; i++) do_write(wv[i].id, wv[i].nbeats, wv[i].bdelay);

    // W beats with no preceding AW must be ignored.
    WVALID = 1'b1; WLAST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("stray_w_wready", WREADY, 0);
      chk("stray_w_bvalid", BVALID, 0);
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;

    chk("concurrent_arready", ARREADY, 1);
    chk("concurrent_awready", AWREADY, 1);
    fork
      do_read(8'h31, 4'd1, 16'hffff);
      do_write(8'h42, 2, 1);
    join

    // Asynchronous reset in the middle of an 8-beat read.
    ARID = 8'h77; ARLEN = 4'd7; ARVALID = 1'b1;
    @(posedge clk); #1;
    ARVALID = 1'b0;
    for (int k = 0; k < 8; k++) r_exp.push_back('{8'h77, k == 7});
    RREADY = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_rvalid", RVALID, 0);
    chk("async_rst_arready", ARREADY, 1);
    chk("async_rst_rlast", RLAST, 0);
    RREADY = 1'b0;
    r_exp.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(8'h05, 4'd0, 16'hffff);

    repeat (3) @(posedge clk);
    #1;
    chk("r_scoreboard_empty", r_exp.size(), 0);
    chk("b_scoreboard_empty", b_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
